// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_pkg;

    // Number of shift-add / shift-subtract iterations for a 32-bit operand.
    localparam int unsigned ITERS = 32;

    // Operation encodings as presented on the op input.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    // True for the signed variants, whose operands are reduced to magnitudes.
    function automatic logic op_is_signed(input op_t o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    // True for the divide variants.
    function automatic logic op_is_div(input op_t o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// mode=0: shift-add multiply step on part = {partial_hi, multiplier_remaining}.
// mode=1: restoring shift-subtract divide step on part = {remainder, dividend_remaining};
//         the new quotient bit is returned on q_bit and the LSB of part_next is left 0.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = ITERS
) (
    input  logic [2*WIDTH-1:0] part,
    input  logic [WIDTH-1:0]   operand,
    input  logic               mode,
    output logic [2*WIDTH-1:0] part_next,
    output logic               q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    // Single iteration: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide.
    always_comb begin
        part_next = '0;
        q_bit     = 1'b0;
        sum       = '0;
        trial     = '0;
        if (!mode) begin
            sum       = {1'b0, part[2*WIDTH-1:WIDTH]} + (part[0] ? {1'b0, operand} : '0);
            part_next = {sum, part[WIDTH-1:1]};
        end else begin
            trial     = part[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
            q_bit     = ~trial[WIDTH];
            part_next = {(q_bit ? trial[WIDTH-1:0] : part[2*WIDTH-2:WIDTH-1]),
                         part[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Fixed latency: start sampled at E0, result in HI/LO and done pulse at E33.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             write_hi,
    input  logic             write_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state;
    op_t                op_q;
    logic               sign_a;
    logic               sign_b;
    logic               b_zero;
    logic [WIDTH-1:0]   raw_a;
    logic [WIDTH-1:0]   oper;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;

    op_t                op_in;
    logic               signed_in;
    logic               div_in;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic               div_mode;
    logic [2*WIDTH-1:0] step_next;
    logic               step_q;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    // Decode the incoming request and reduce signed operands to magnitudes.
    always_comb begin
        op_in     = op_t'(op);
        signed_in = op_is_signed(op_in);
        div_in    = op_is_div(op_in);
        mag_a     = (signed_in && rs_data[WIDTH-1]) ? (~rs_data + 1'b1) : rs_data;
        mag_b     = (signed_in && rt_data[WIDTH-1]) ? (~rt_data + 1'b1) : rt_data;
    end

    assign div_mode = op_is_div(op_q);

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .part      (acc),
        .operand   (oper),
        .mode      (div_mode),
        .part_next (step_next),
        .q_bit     (step_q)
    );

    // Sign correction and divide-by-zero override applied to the finished magnitude result.
    always_comb begin
        prod   = acc;
        quot   = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        fin_hi = '0;
        fin_lo = '0;
        if (op_q == OP_MULT && (sign_a ^ sign_b)) begin
            prod = ~acc + 1'b1;
        end
        if (op_q == OP_DIV) begin
            if (sign_a ^ sign_b) begin
                quot = ~acc[WIDTH-1:0] + 1'b1;
            end
            if (sign_a) begin
                rem = ~acc[2*WIDTH-1:WIDTH] + 1'b1;
            end
        end
        if (div_mode) begin
            if (b_zero) begin
                fin_hi = raw_a;
                fin_lo = '1;
            end else begin
                fin_hi = rem;
                fin_lo = quot;
            end
        end else begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

    // Sequencer: operand capture in IDLE, one datapath step per RUN cycle, HI/LO writeback in FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= OP_MULT;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            raw_a  <= '0;
            oper   <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (write_hi) begin
                        hi <= wdata;
                    end
                    if (write_lo) begin
                        lo <= wdata;
                    end
                    if (start) begin
                        op_q   <= op_in;
                        sign_a <= signed_in & rs_data[WIDTH-1];
                        sign_b <= signed_in & rt_data[WIDTH-1];
                        b_zero <= (rt_data == '0);
                        raw_a  <= rs_data;
                        // Multiply walks the multiplier through the low half; divide walks the dividend.
                        acc    <= div_in ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                        oper   <= div_in ? mag_b : mag_a;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc   <= step_next | {{(2*WIDTH-1){1'b0}}, step_q};
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    hi    <= fin_hi;
                    lo    <= fin_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, handshake rules,
// reset mid-operation and randomized back-to-back operations against an arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        write_hi;
    logic        write_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(
        .WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .write_hi (write_hi),
        .write_lo (write_lo),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    // Reference: MIPS-style HI/LO results from plain 64-bit arithmetic.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] eh, output logic [31:0] el);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        eh = '0;
        el = '0;
        if (o == 2'd0) begin
            p = longint'($signed(a)) * longint'($signed(b));
            {eh, el} = p;
        end else if (o == 2'd1) begin
            up = {32'd0, a} * {32'd0, b};
            {eh, el} = up;
        end else if (b == 32'd0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
        end else if (o == 2'd2) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            el = q[31:0];
            eh = r[31:0];
        end else begin
            el = a / b;
            eh = a % b;
        end
    endfunction

    // Present a request for exactly one edge (E0); returns 1 time unit after E0.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op      = o;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
        write_hi = 1'b0; write_lo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed;
        logic [1:0]  t_op [6] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3};
        logic [31:0] t_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd5};
        logic [31:0] t_b  [6] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0};
        logic [31:0] t_hi [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd5};
        logic [31:0] t_lo [6] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd3, 32'h80000000, 32'hFFFFFFFF};
        int          bad_cyc;
        for (int i = 0; i < 6; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            bad_cyc = 0;
            // Between E0 and E32 the unit must stay busy without signalling done.
            for (int c = 0; c < 33; c++) begin
                if (busy !== 1'b1 || done !== 1'b0) bad_cyc++;
                if (c < 32) begin
                    @(posedge clk);
                    #1;
                end
            end
            vectors++;
            if (bad_cyc != 0) begin
                errors++;
                $display("FAIL directed%0d_busy_window: %0d cycles with busy!=1 or done!=0, required 0", i, bad_cyc);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL directed%0d_done_e33: done=%b busy=%b, required done=1 busy=0", i, done, busy);
            end
            vectors++;
            if (hi !== t_hi[i] || lo !== t_lo[i]) begin
                errors++;
                $display("FAIL directed%0d_result: hi=%h lo=%h, required hi=%h lo=%h", i, hi, lo, t_hi[i], t_lo[i]);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL directed%0d_done_pulse: done=%b one cycle later, required 0", i, done);
            end
        end
    endtask

    task automatic test_handshake;
        logic [31:0] a, b, eh, el, eh2, el2, keep_hi;
        a = 32'h0001_2345;
        b = 32'h0000_0F0F;
        ref_model(2'd1, a, b, eh, el);
        issue(2'd1, a, b);
        // Reach the cycle before E10, then hold a new start and MTHI across E10.
        repeat (9) @(posedge clk);
        #1;
        op = 2'd3; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
        write_hi = 1'b1; wdata = 32'h1234;
        @(posedge clk);
        #1;
        start = 1'b0; write_hi = 1'b0;
        vectors++;
        if (hi === 32'h1234) begin
            errors++;
            $display("FAIL mthi_while_busy: hi=%h, required unchanged from 00001234", hi);
        end
        repeat (22) @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL handshake_e32: done=%b busy=%b, required done=0 busy=1", done, busy);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || hi !== eh || lo !== el) begin
            errors++;
            $display("FAIL start_while_busy_ignored: done=%b hi=%h lo=%h, required done=1 hi=%h lo=%h",
                     done, hi, lo, eh, el);
        end
        // Back-to-back: new request presented during the done cycle.
        ref_model(2'd2, 32'hFFFF_FF00, 32'd16, eh2, el2);
        issue(2'd2, 32'hFFFF_FF00, 32'd16);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        repeat (33) @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || hi !== eh2 || lo !== el2) begin
            errors++;
            $display("FAIL back_to_back_result: done=%b hi=%h lo=%h, required done=1 hi=%h lo=%h",
                     done, hi, lo, eh2, el2);
        end
        @(posedge clk);
        #1;
        // MTLO in IDLE updates LO at the next edge and leaves HI alone.
        keep_hi = hi;
        write_lo = 1'b1; wdata = 32'h0000_ABCD;
        @(posedge clk);
        #1;
        write_lo = 1'b0;
        vectors++;
        if (lo !== 32'h0000_ABCD || hi !== keep_hi) begin
            errors++;
            $display("FAIL mtlo_idle: hi=%h lo=%h, required hi=%h lo=0000abcd", hi, lo, keep_hi);
        end
        // MTHI together with start: write lands now, result overwrites at FIN.
        ref_model(2'd0, 32'd6, 32'hFFFF_FFFE, eh, el);
        write_hi = 1'b1; wdata = 32'h5A5A_0001;
        issue(2'd0, 32'd6, 32'hFFFF_FFFE);
        write_hi = 1'b0;
        vectors++;
        if (hi !== 32'h5A5A_0001) begin
            errors++;
            $display("FAIL mthi_with_start: hi=%h, required 5a5a0001", hi);
        end
        repeat (33) @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || hi !== eh || lo !== el) begin
            errors++;
            $display("FAIL mthi_with_start_result: done=%b hi=%h lo=%h, required done=1 hi=%h lo=%h",
                     done, hi, lo, eh, el);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op;
        issue(2'd1, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(2'd1, 32'd3, 32'd4);
        repeat (33) @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd12) begin
            errors++;
            $display("FAIL after_reset_multu: done=%b hi=%h lo=%h, required done=1 hi=0 lo=c", done, hi, lo);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random_back_to_back;
        logic [1:0]  o;
        logic [31:0] a, b, eh, el;
        int          sel;
        for (int n = 0; n < 60; n++) begin
            o   = 2'($urandom_range(0, 3));
            a   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = 32'd0;
            else if (sel == 1) b = 32'($urandom_range(1, 15));
            else if (sel == 2) b = 32'hFFFF_FFFF;
            else               b = $urandom;
            if (sel == 3) a = 32'h8000_0000;
            ref_model(o, a, b, eh, el);
            // Each request is issued in the done cycle of the previous one.
            issue(o, a, b);
            repeat (33) @(posedge clk);
            #1;
            vectors++;
            if (done !== 1'b1 || hi !== eh || lo !== el) begin
                errors++;
                $display("FAIL random%0d op=%0d a=%h b=%h: done=%b hi=%h lo=%h, required done=1 hi=%h lo=%h",
                         n, o, a, b, done, hi, lo, eh, el);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_reset_mid_op();
        test_random_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
